// File: rtl/pre_emphasis_mc.sv
// Multi-channel pre-emphasis filter: y[n] = x[n] - alpha*x[n-1] per channel.
// Time-interleaved channels keep independent history; two-stage valid/ready
// pipeline with full backpressure, runtime alpha, bypass and output saturation.
module pre_emphasis_mc #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NUM_CH = 2,
   parameter int CH_W   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [CH_W-1:0]   s_ch,
   input  logic              s_first,
   input  logic [COEF_W-1:0] cfg_alpha,
   input  logic              cfg_bypass,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_ch,
   output logic              m_first,
   output logic              sat_flag,
   output logic              ch_err,
   input  logic              flag_clr
);

   // Product width: signed sample times unsigned coefficient, full precision.
   localparam int PW = DATA_W + COEF_W + 1;
   // Difference width: two guard bits above the sample width.
   localparam int DW = DATA_W + 2;

   localparam logic [CH_W:0]        NUM_CH_L = (CH_W + 1)'(NUM_CH);
   localparam logic signed [PW-1:0] ROUND_C  = PW'(2 ** (COEF_W - 1));
   localparam logic [DATA_W-1:0]    SAT_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic [DATA_W-1:0]    SAT_MIN  = {1'b1, {(DATA_W - 1){1'b0}}};

   // Per-channel previous-sample history.
   logic [DATA_W-1:0] hist [NUM_CH];

   // Stage 1 registers.
   logic              s1_valid;
   logic [DATA_W-1:0] s1_x;
   logic [DATA_W-1:0] s1_prev;
   logic [COEF_W-1:0] s1_alpha;
   logic              s1_bypass;
   logic [CH_W-1:0]   s1_ch;
   logic              s1_first;

   // Handshake and channel qualification.
   logic adv1;
   logic adv2;
   logic accept;
   logic ch_ok;

   // Stage 1 history read.
   logic [DATA_W-1:0] prev_sel;

   // Stage 2 arithmetic.
   logic signed [PW-1:0] prev_ext;
   logic signed [PW-1:0] alpha_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_rnd;
   logic signed [PW-1:0] q_full;
   logic [DW-1:0]        diff;
   logic [DATA_W-1:0]    y_next;
   logic                 sat_now;

   // The output stage moves when it is empty or being drained; stage 1 moves
   // when it is empty or the output stage can take its contents.
   assign adv2    = !m_valid || m_ready;
   assign adv1    = !s1_valid || adv2;
   assign s_ready = adv1;
   assign accept  = s_valid && adv1;
   assign ch_ok   = ({1'b0, s_ch} < NUM_CH_L);

   // Select the channel's previous sample, forced to zero at a stream start.
   always_comb begin
      prev_sel = '0;
      if (!s_first) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
               prev_sel = hist[i];
            end
         end
      end
   end

   // History update: the old value was already captured into s1_prev this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hist[i] <= '0;
         end
      end else if (accept && ch_ok) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
               hist[i] <= s_data;
            end
         end
      end
   end

   // Stage 1: capture the sample, its predecessor and the config in effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_x      <= '0;
         s1_prev   <= '0;
         s1_alpha  <= '0;
         s1_bypass <= 1'b0;
         s1_ch     <= '0;
         s1_first  <= 1'b0;
      end else if (adv1) begin
         s1_valid <= accept && ch_ok;
         if (accept) begin
            s1_x      <= s_data;
            s1_prev   <= prev_sel;
            s1_alpha  <= cfg_alpha;
            s1_bypass <= cfg_bypass;
            s1_ch     <= s_ch;
            s1_first  <= s_first;
         end
      end
   end

   // Stage 2 datapath: rounded prev*alpha, subtract, then clamp to range.
   always_comb begin
      prev_ext  = {{(PW - DATA_W){s1_prev[DATA_W-1]}}, s1_prev};
      alpha_ext = {{(PW - COEF_W){1'b0}}, s1_alpha};
      prod      = prev_ext * alpha_ext;
      prod_rnd  = prod + ROUND_C;
      q_full    = prod_rnd >>> COEF_W;
      diff      = {{2{s1_x[DATA_W-1]}}, s1_x} - q_full[DW-1:0];
      sat_now   = 1'b0;
      y_next    = diff[DATA_W-1:0];
      if (s1_bypass) begin
         y_next = s1_x;
      end else if (diff[DW-1:DATA_W-1] != {3{diff[DW-1]}}) begin
         sat_now = 1'b1;
         y_next  = diff[DW-1] ? SAT_MIN : SAT_MAX;
      end
   end

   // Output register: holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_ch    <= '0;
         m_first <= 1'b0;
      end else if (adv2) begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data  <= y_next;
            m_ch    <= s1_ch;
            m_first <= s1_first;
         end
      end
   end

   // Sticky status flags; a new event in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag <= 1'b0;
         ch_err   <= 1'b0;
      end else begin
         if (adv2 && s1_valid && sat_now) begin
            sat_flag <= 1'b1;
         end else if (flag_clr) begin
            sat_flag <= 1'b0;
         end
         if (accept && !ch_ok) begin
            ch_err <= 1'b1;
         end else if (flag_clr) begin
            ch_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pre_emphasis_mc.sv
// Self-checking bench for pre_emphasis_mc: directed scenarios plus a
// randomized stream scored against a behavioural model of the filter.
module tb_pre_emphasis_mc;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic [1:0]  s_ch;
   logic        s_first;
   logic [15:0] cfg_alpha;
   logic        cfg_bypass;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [1:0]  m_ch;
   logic        m_first;
   logic        sat_flag;
   logic        ch_err;
   logic        flag_clr;

   typedef struct {
      int data;
      int ch;
      bit first;
   } sample_t;

   sample_t exp_q[$];
   sample_t obs_q[$];
   longint  model_hist [4];
   bit      exp_sat;
   bit      exp_err;
   int      acc_count;
   int      n_checks;
   int      n_pass;

   pre_emphasis_mc #(
      .DATA_W (16),
      .COEF_W (16),
      .NUM_CH (2),
      .CH_W   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_ch       (s_ch),
      .s_first    (s_first),
      .cfg_alpha  (cfg_alpha),
      .cfg_bypass (cfg_bypass),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_ch       (m_ch),
      .m_first    (m_first),
      .sat_flag   (sat_flag),
      .ch_err     (ch_err),
      .flag_clr   (flag_clr)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if something wedges the run.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic longint floor_div(longint a, longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // Behavioural filter: y = x - round_half_up(prev*alpha/65536), clamped.
   function automatic void model_accept(int x, int ch, bit first, int alpha, bit byp);
      longint prev;
      longint q;
      longint d;
      sample_t s;
      if (ch >= 2) begin
         exp_err = 1'b1;
         return;
      end
      prev = first ? 0 : model_hist[ch];
      if (byp) begin
         d = x;
      end else begin
         q = floor_div(prev * alpha + 32768, 65536);
         d = x - q;
         if (d > 32767) begin
            d = 32767;
            exp_sat = 1'b1;
         end else if (d < -32768) begin
            d = -32768;
            exp_sat = 1'b1;
         end
      end
      s.data  = int'(d);
      s.ch    = ch;
      s.first = first;
      exp_q.push_back(s);
      model_hist[ch] = x;
   endfunction

   // One clock: record handshakes implied by the current inputs, then advance.
   task automatic step();
      sample_t s;
      #1;
      if (s_valid && s_ready) begin
         acc_count++;
         model_accept(int'($signed(s_data)), int'(s_ch), s_first, int'(cfg_alpha), cfg_bypass);
      end
      if (m_valid && m_ready) begin
         s.data  = int'($signed(m_data));
         s.ch    = int'(m_ch);
         s.first = m_first;
         obs_q.push_back(s);
      end
      @(negedge clk);
   endtask

   task automatic send(int x, int ch, bit first);
      s_valid = 1'b1;
      s_data  = 16'(x);
      s_ch    = 2'(ch);
      s_first = first;
      step();
      s_valid = 1'b0;
   endtask

   task automatic drain();
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic pulse_clear();
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
   endtask

   task automatic clear_queues();
      exp_q.delete();
      obs_q.delete();
      acc_count = 0;
   endtask

   task automatic test_reset();
      n_checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== 16'd0) $display("[TB] FAIL reset_m_data: got %0d want 0", m_data); else n_pass++;
      n_checks++; if (m_first !== 1'b0 || m_ch !== 2'd0) $display("[TB] FAIL reset_m_ch_first: got %0d/%b want 0/0", m_ch, m_first); else n_pass++;
      n_checks++; if (sat_flag !== 1'b0 || ch_err !== 1'b0) $display("[TB] FAIL reset_flags: got %b%b want 00", sat_flag, ch_err); else n_pass++;
      n_checks++; if (s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
   endtask

   task automatic test_basic();
      int ed[$] = '{1000, 30};
      bit ef[$] = '{1'b1, 1'b0};
      clear_queues();
      m_ready = 1'b1;
      cfg_alpha = 16'hF852;
      cfg_bypass = 1'b0;
      send(1000, 0, 1'b1);
      n_checks++; if (m_valid !== 1'b0) $display("[TB] FAIL basic_latency1: got m_valid %b want 0", m_valid); else n_pass++;
      send(1000, 0, 1'b0);
      n_checks++; if (m_valid !== 1'b1 || m_data !== 16'd1000) $display("[TB] FAIL basic_latency2: got %b/%0d want 1/1000", m_valid, $signed(m_data)); else n_pass++;
      drain();
      n_checks++; if (obs_q.size() !== 2) $display("[TB] FAIL basic_count: got %0d want 2", obs_q.size()); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i].data !== ed[i] || obs_q[i].first !== ef[i])
            $display("[TB] FAIL basic_out%0d: got %0d/%b want %0d/%b", i,
                     (i < obs_q.size()) ? obs_q[i].data : 0, (i < obs_q.size()) ? obs_q[i].first : 1'b0, ed[i], ef[i]);
         else n_pass++;
      end
   endtask

   task automatic test_interleave();
      int ed[$] = '{1000, -2000, 30, -60};
      int ec[$] = '{0, 1, 0, 1};
      clear_queues();
      s_valid = 1'b1;
      s_data = 16'(1000);  s_ch = 2'd0; s_first = 1'b1; step();
      s_data = 16'(-2000); s_ch = 2'd1; s_first = 1'b1; step();
      s_data = 16'(1000);  s_ch = 2'd0; s_first = 1'b0; step();
      s_data = 16'(-2000); s_ch = 2'd1; s_first = 1'b0; step();
      drain();
      n_checks++; if (obs_q.size() !== 4) $display("[TB] FAIL interleave_count: got %0d want 4", obs_q.size()); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i].data !== ed[i] || obs_q[i].ch !== ec[i])
            $display("[TB] FAIL interleave_out%0d: got %0d ch%0d want %0d ch%0d", i,
                     (i < obs_q.size()) ? obs_q[i].data : 0, (i < obs_q.size()) ? obs_q[i].ch : 0, ed[i], ec[i]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      clear_queues();
      cfg_alpha = 16'hF852;
      send(32767, 0, 1'b1);
      send(-32768, 0, 1'b0);
      drain();
      n_checks++;
      if (obs_q.size() !== 2 || obs_q[obs_q.size()-1].data !== -32768)
         $display("[TB] FAIL sat_value: got n=%0d last=%0d want n=2 last=-32768", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 0);
      else n_pass++;
      n_checks++; if (sat_flag !== 1'b1) $display("[TB] FAIL sat_flag_set: got %b want 1", sat_flag); else n_pass++;
      pulse_clear();
      n_checks++; if (sat_flag !== 1'b0) $display("[TB] FAIL sat_flag_clr: got %b want 0", sat_flag); else n_pass++;
      send(32767, 0, 1'b1);
      send(-32768, 0, 1'b0);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      n_checks++; if (sat_flag !== 1'b1) $display("[TB] FAIL sat_set_beats_clr: got %b want 1", sat_flag); else n_pass++;
      drain();
      pulse_clear();
   endtask

   task automatic test_backpressure();
      logic [15:0] held;
      clear_queues();
      cfg_alpha = 16'h8000;
      m_ready = 1'b0;
      s_valid = 1'b1;
      held = '0;
      for (int k = 0; k < 5; k++) begin
         s_data = 16'(100 * (k + 1));
         s_ch = 2'(k % 2);
         s_first = (k < 2);
         step();
         if (k == 2) held = m_data;
      end
      n_checks++; if (acc_count !== 2) $display("[TB] FAIL bp_accepts: got %0d want 2", acc_count); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("[TB] FAIL bp_s_ready: got %b want 0", s_ready); else n_pass++;
      n_checks++; if (m_valid !== 1'b1 || m_data !== held || m_data !== 16'd100) $display("[TB] FAIL bp_stable: got %0d want 100", m_data); else n_pass++;
      m_ready = 1'b1;
      for (int k = 5; k < 9; k++) begin
         s_data = 16'(100 * (k + 1));
         s_ch = 2'(k % 2);
         s_first = 1'b0;
         step();
      end
      drain();
      n_checks++; if (obs_q.size() !== exp_q.size() || obs_q.size() < 4) $display("[TB] FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].ch !== exp_q[i].ch)
            $display("[TB] FAIL bp_out%0d: got %0d ch%0d want %0d ch%0d", i,
                     (i < obs_q.size()) ? obs_q[i].data : 0, (i < obs_q.size()) ? obs_q[i].ch : 0, exp_q[i].data, exp_q[i].ch);
         else n_pass++;
      end
   endtask

   task automatic test_bypass_illegal();
      int ed[$] = '{500, 600, 118};
      clear_queues();
      cfg_alpha = 16'hF852;
      cfg_bypass = 1'b1;
      send(500, 0, 1'b1);
      send(600, 0, 1'b0);
      cfg_bypass = 1'b0;
      send(700, 0, 1'b0);
      drain();
      n_checks++; if (obs_q.size() !== 3) $display("[TB] FAIL bypass_count: got %0d want 3", obs_q.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i].data !== ed[i])
            $display("[TB] FAIL bypass_out%0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i].data : 0, ed[i]);
         else n_pass++;
      end
      n_checks++; if (ch_err !== 1'b0) $display("[TB] FAIL ch_err_idle: got %b want 0", ch_err); else n_pass++;
      send(1234, 3, 1'b0);
      drain();
      n_checks++; if (obs_q.size() !== 3) $display("[TB] FAIL illegal_no_output: got %0d want 3", obs_q.size()); else n_pass++;
      n_checks++; if (ch_err !== 1'b1) $display("[TB] FAIL ch_err_set: got %b want 1", ch_err); else n_pass++;
      pulse_clear();
      n_checks++; if (ch_err !== 1'b0) $display("[TB] FAIL ch_err_clr: got %b want 0", ch_err); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      clear_queues();
      m_ready = 1'b1;
      cfg_alpha = 16'hF852;
      cfg_bypass = 1'b0;
      send(1000, 0, 1'b1);
      send(1000, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++; if (m_valid !== 1'b0) $display("[TB] FAIL rst_mid_m_valid: got %b want 0", m_valid); else n_pass++;
      for (int i = 0; i < 4; i++) model_hist[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_queues();
      send(500, 0, 1'b0);
      send(-300, 1, 1'b0);
      drain();
      n_checks++;
      if (obs_q.size() !== 2 || obs_q[0].data !== 500 || obs_q[1].data !== -300)
         $display("[TB] FAIL rst_mid_prev_zero: got n=%0d first=%0d want n=2 500,-300", obs_q.size(),
                  (obs_q.size() > 0) ? obs_q[0].data : 0);
      else n_pass++;
   endtask

   task automatic test_random();
      int sel;
      pulse_clear();
      exp_sat = 1'b0;
      exp_err = 1'b0;
      clear_queues();
      for (int c = 0; c < 400; c++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 15);
         s_ch = (sel == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         s_data = 16'($urandom);
         s_first = ($urandom_range(0, 7) == 0);
         sel = $urandom_range(0, 5);
         cfg_alpha = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
         cfg_bypass = ($urandom_range(0, 7) == 0);
         m_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
      n_checks++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].ch !== exp_q[i].ch || obs_q[i].first !== exp_q[i].first)
            $display("[TB] FAIL rand_out%0d: got %0d ch%0d want %0d ch%0d", i,
                     (i < obs_q.size()) ? obs_q[i].data : 0, (i < obs_q.size()) ? obs_q[i].ch : 0, exp_q[i].data, exp_q[i].ch);
         else n_pass++;
      end
      n_checks++; if (sat_flag !== exp_sat) $display("[TB] FAIL rand_sat_flag: got %b want %b", sat_flag, exp_sat); else n_pass++;
      n_checks++; if (ch_err !== exp_err) $display("[TB] FAIL rand_ch_err: got %b want %b", ch_err, exp_err); else n_pass++;
   endtask

   // Sequence all scenarios, then report.
   initial begin
      n_checks = 0;
      n_pass = 0;
      acc_count = 0;
      exp_sat = 1'b0;
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) model_hist[i] = 0;
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_ch = '0;
      s_first = 1'b0;
      cfg_alpha = '0;
      cfg_bypass = 1'b0;
      m_ready = 1'b1;
      flag_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_interleave();
      test_saturation();
      test_backpressure();
      test_bypass_illegal();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
